// File: rtl/vga_timing_pkg.sv
// Shared types and standard mode timings for the VGA raster timing generator.
// Optional frame counter in vga_timing_gen is enabled by defining VGA_TIMING_FRAME_CNT_EN.
package vga_timing_pkg;

  // Widest coordinate any configuration may use; pipeline entries are sized to it.
  localparam int VGA_CW_MAX = 16;

  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam bit VGA640_H_POL     = 1'b0;
  localparam bit VGA640_V_POL     = 1'b0;
  localparam int VGA640_CW        = 10;

  localparam int VGA800_H_VISIBLE = 800;
  localparam int VGA800_H_FRONT   = 40;
  localparam int VGA800_H_SYNC    = 128;
  localparam int VGA800_H_BACK    = 88;
  localparam int VGA800_V_VISIBLE = 600;
  localparam int VGA800_V_FRONT   = 1;
  localparam int VGA800_V_SYNC    = 4;
  localparam int VGA800_V_BACK    = 23;
  localparam bit VGA800_H_POL     = 1'b1;
  localparam bit VGA800_V_POL     = 1'b1;
  localparam int VGA800_CW        = 11;

  typedef struct packed {
    logic [VGA_CW_MAX-1:0] x;
    logic [VGA_CW_MAX-1:0] y;
    logic                  de;
    logic                  hs_act;
    logic                  vs_act;
    logic                  sol;
    logic                  sof;
  } vga_tim_entry_t;

  // All-zero entry: invisible, syncs inactive, no strobes.
  localparam vga_tim_entry_t VGA_BLANK_ENTRY = '0;

endpackage

// File: rtl/vga_timing_delay.sv
// Advance-gated shift register of raster entries; its depth is the fetch-to-display lead.
module vga_timing_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  input  vga_tim_entry_t din,
  output vga_tim_entry_t dout,
  output vga_tim_entry_t pre_last
);

  vga_tim_entry_t stage_q [DEPTH];
  vga_tim_entry_t stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (adv) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= VGA_BLANK_ENTRY;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

  // Entry that the next advance moves into the display slot, used to time the strobes.
  generate
    if (DEPTH == 1) begin : g_pre_din
      assign pre_last = din;
    end else begin : g_pre_stage
      assign pre_last = stage_q[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: fetch counters lead the sync/enable/strobe outputs by LOOKAHEAD advances.
// Define VGA_TIMING_FRAME_CNT_EN to build the frame_count counter; otherwise frame_count is tied to 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = VGA640_H_VISIBLE,
  parameter int H_FRONT    = VGA640_H_FRONT,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BACK     = VGA640_H_BACK,
  parameter int V_VISIBLE  = VGA640_V_VISIBLE,
  parameter int V_FRONT    = VGA640_V_FRONT,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BACK     = VGA640_V_BACK,
  parameter bit H_SYNC_POL = VGA640_H_POL,
  parameter bit V_SYNC_POL = VGA640_V_POL,
  parameter int LOOKAHEAD  = 2,
  parameter int CW         = VGA640_CW,
  parameter int FCW        = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  output logic [CW-1:0]  fetch_x,
  output logic [CW-1:0]  fetch_y,
  output logic           fetch_valid,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           display_en,
  output logic           h_sync,
  output logic           v_sync,
  output logic           line_start,
  output logic           frame_start,
  output logic           vblank,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (LOOKAHEAD < 1 || LOOKAHEAD > 4) begin : g_bad_lookahead
      $error("vga_timing_gen: LOOKAHEAD must be in 1..4");
    end
    if (CW > VGA_CW_MAX || (H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for the configured totals");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SS   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_SE   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_SE   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0]  fx_q, fx_d, fy_q, fy_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  vga_tim_entry_t fetch_ent, disp_ent, pre_ent;

  always_comb begin
    fx_d = fx_q;
    fy_d = fy_q;
    if (pix_en) begin
      if (fx_q == H_LAST) begin
        fx_d = '0;
        fy_d = (fy_q == V_LAST) ? '0 : fy_q + CW'(1);
      end else begin
        fx_d = fx_q + CW'(1);
      end
    end
  end

  always_comb begin
    fetch_ent        = VGA_BLANK_ENTRY;
    fetch_ent.x      = VGA_CW_MAX'(fx_q);
    fetch_ent.y      = VGA_CW_MAX'(fy_q);
    fetch_ent.de     = (fx_q < H_VIS) && (fy_q < V_VIS);
    fetch_ent.hs_act = (fx_q >= H_SS) && (fx_q < H_SE);
    fetch_ent.vs_act = (fy_q >= V_SS) && (fy_q < V_SE);
    fetch_ent.sol    = (fx_q == '0);
    fetch_ent.sof    = (fx_q == '0) && (fy_q == '0);
  end

  vga_timing_delay #(
    .DEPTH (LOOKAHEAD)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .adv      (pix_en),
    .din      (fetch_ent),
    .dout     (disp_ent),
    .pre_last (pre_ent)
  );

  // Strobes fire only on the advance that moves a start entry into the display slot.
  always_comb begin
    line_start_d  = pix_en & pre_ent.sol;
    frame_start_d = pix_en & pre_ent.sof;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fx_q          <= '0;
      fy_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      fx_q          <= fx_d;
      fy_q          <= fy_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;
  assign fetch_valid = fetch_ent.de;
  assign x           = disp_ent.x[CW-1:0];
  assign y           = disp_ent.y[CW-1:0];
  assign display_en  = disp_ent.de;
  assign h_sync      = disp_ent.hs_act ^ ~H_SYNC_POL;
  assign v_sync      = disp_ent.vs_act ^ ~V_SYNC_POL;
  assign vblank      = disp_ent.y[CW-1:0] >= V_VIS;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  logic unused_entry_bits;
  assign unused_entry_bits = ^{disp_ent, pre_ent};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations share clk/rst/pix_en and are checked against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  // A: 640x480 defaults
  logic [9:0]  a_fx, a_fy, a_x, a_y;
  logic        a_fv, a_de, a_hs, a_vs, a_ls, a_fs, a_vb;
  logic [15:0] a_fc;
  // S: tiny raster (15x8), active-high syncs, LOOKAHEAD 3, FCW 2
  logic [4:0]  s_fx, s_fy, s_x, s_y;
  logic        s_fv, s_de, s_hs, s_vs, s_ls, s_fs, s_vb;
  logic [1:0]  s_fc;
  // C: 800x600
  logic [10:0] c_fx, c_fy, c_x, c_y;
  logic        c_fv, c_de, c_hs, c_vs, c_ls, c_fs, c_vb;
  logic [15:0] c_fc;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv),
    .x(a_x), .y(a_y), .display_en(a_de), .h_sync(a_hs), .v_sync(a_vs), .line_start(a_ls),
    .frame_start(a_fs), .vblank(a_vb), .frame_count(a_fc));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LOOKAHEAD(3), .CW(5), .FCW(2)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en), .fetch_x(s_fx), .fetch_y(s_fy), .fetch_valid(s_fv),
    .x(s_x), .y(s_y), .display_en(s_de), .h_sync(s_hs), .v_sync(s_vs), .line_start(s_ls),
    .frame_start(s_fs), .vblank(s_vb), .frame_count(s_fc));

  vga_timing_gen #(
    .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LOOKAHEAD(2), .CW(11), .FCW(16)
  ) dut_c (
    .clk(clk), .rst(rst), .pix_en(pix_en), .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv),
    .x(c_x), .y(c_y), .display_en(c_de), .h_sync(c_hs), .v_sync(c_vs), .line_start(c_ls),
    .frame_start(c_fs), .vblank(c_vb), .frame_count(c_fc));

  int checks = 0;
  int errors = 0;

  // Reference state: advances since the last reset, and whether the last edge advanced.
  int m_n = 0;
  bit m_adv = 1'b0;

  task automatic chk(input string dut, input string field, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", dut, field, act, exp);
    end
  endtask

  task automatic chk_dut(input string nm,
                         input int hv, input int hf, input int hs, input int hb,
                         input int vv, input int vf, input int vs, input int vb,
                         input bit hp, input bit vp, input int la, input int fcw,
                         input int fx, input int fy, input bit fv, input int ax, input int ay,
                         input bit de, input bit hsy, input bit vsy, input bit vbl,
                         input bit ls, input bit fs, input longint fc);
    int ht, vt, ex_fx, ex_fy, p, dx, dy;
    bit blank, hact, vact;
    longint frames;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    ex_fx = m_n % ht;
    ex_fy = (m_n / ht) % vt;
    blank = (m_n < la);
    p = blank ? 0 : m_n - la;
    dx = p % ht;
    dy = (p / ht) % vt;
    hact = !blank && dx >= hv + hf && dx < hv + hf + hs;
    vact = !blank && dy >= vv + vf && dy < vv + vf + vs;
    chk(nm, "fetch_x", fx, ex_fx);
    chk(nm, "fetch_y", fy, ex_fy);
    chk(nm, "fetch_valid", fv, (ex_fx < hv) && (ex_fy < vv));
    chk(nm, "x", ax, dx);
    chk(nm, "y", ay, dy);
    chk(nm, "display_en", de, !blank && dx < hv && dy < vv);
    chk(nm, "h_sync", hsy, hp ? hact : !hact);
    chk(nm, "v_sync", vsy, vp ? vact : !vact);
    chk(nm, "vblank", vbl, !blank && dy >= vv);
    chk(nm, "line_start", ls, m_adv && !blank && dx == 0);
    chk(nm, "frame_start", fs, m_adv && !blank && dx == 0 && dy == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    frames = blank ? 0 : (longint'(m_n - la) / (ht * vt)) + 1;
    chk(nm, "frame_count", fc, frames % (longint'(1) << fcw));
`else
    frames = 0;
    chk(nm, "frame_count", fc, frames);
`endif
  endtask

  task automatic check_all();
    chk_dut("A", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 16,
            a_fx, a_fy, a_fv, a_x, a_y, a_de, a_hs, a_vs, a_vb, a_ls, a_fs, a_fc);
    chk_dut("S", 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, 3, 2,
            s_fx, s_fy, s_fv, s_x, s_y, s_de, s_hs, s_vs, s_vb, s_ls, s_fs, s_fc);
    chk_dut("C", 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 2, 16,
            c_fx, c_fy, c_fv, c_x, c_y, c_de, c_hs, c_vs, c_vb, c_ls, c_fs, c_fc);
  endtask

  // Drive at the falling edge, let one rising edge happen, then compare at the next falling edge.
  task automatic tick(input bit r, input bit e);
    rst = r;
    pix_en = e;
    @(posedge clk);
    if (r) begin
      m_n = 0;
      m_adv = 1'b0;
    end else if (e) begin
      m_n++;
      m_adv = 1'b1;
    end else begin
      m_adv = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit r; bit e; int fx; int fy; int x; bit de; bit ls; bit fs;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int cnt_hs, cnt_de, cnt_ls, cnt_vs, cnt_vb, cnt_c, fs_seen, steps;
    bit found;

    tbl[0] = '{1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 3, 0, 0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 3, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4, 0, 1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);

    // Small raster: reset, first advances, pix_en holds, strobe timing, reset again.
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].r, tbl[i].e);
      chk($sformatf("tbl%0d", i), "fetch_x", s_fx, tbl[i].fx);
      chk($sformatf("tbl%0d", i), "fetch_y", s_fy, tbl[i].fy);
      chk($sformatf("tbl%0d", i), "x", s_x, tbl[i].x);
      chk($sformatf("tbl%0d", i), "display_en", s_de, tbl[i].de);
      chk($sformatf("tbl%0d", i), "line_start", s_ls, tbl[i].ls);
      chk($sformatf("tbl%0d", i), "frame_start", s_fs, tbl[i].fs);
    end

    // Defaults right after reset, then release with pix_en=1.
    chk("rst_a", "fetch_x", a_fx, 0);
    chk("rst_a", "display_en", a_de, 0);
    chk("rst_a", "h_sync", a_hs, 1);
    chk("rst_a", "v_sync", a_vs, 1);
    chk("rst_a", "vblank", a_vb, 0);
    chk("rst_a", "frame_count", a_fc, 0);
    tick(1'b0, 1'b1);
    chk("rel_a1", "frame_start", a_fs, 0);
    tick(1'b0, 1'b1);
    chk("rel_a2", "frame_start", a_fs, 1);
    chk("rel_a2", "line_start", a_ls, 1);
    chk("rel_a2", "x", a_x, 0);
    chk("rel_a2", "y", a_y, 0);
    chk("rel_a2", "display_en", a_de, 1);
    chk("rel_c2", "frame_start", c_fs, 1);
    tick(1'b0, 1'b1);
    chk("rel_a3", "frame_start", a_fs, 0);

    // Full-rate line statistics.
    cnt_hs = 0; cnt_de = 0; cnt_ls = 0; cnt_vs = 0; cnt_vb = 0; cnt_c = 0;
    for (int i = 0; i < 2400; i++) begin
      tick(1'b0, 1'b1);
      cnt_hs += (a_hs == 1'b0);
      cnt_de += a_de;
      cnt_ls += a_ls;
      cnt_vs += (a_vs == 1'b0);
      cnt_vb += a_vb;
      if (i < 2112) cnt_c += c_hs;
    end
    chk("full_rate", "h_sync_low_clks", cnt_hs, 288);
    chk("full_rate", "display_en_clks", cnt_de, 1920);
    chk("full_rate", "line_starts", cnt_ls, 3);
    chk("full_rate", "v_sync_low_clks", cnt_vs, 0);
    chk("full_rate", "vblank_clks", cnt_vb, 0);
    chk("full_rate", "c_h_sync_high_clks", cnt_c, 256);

    // Half-rate: periods double, strobes stay one clock wide.
    cnt_hs = 0; cnt_ls = 0; cnt_c = 0;
    for (int i = 0; i < 3200; i++) begin
      tick(1'b0, (i % 2) == 0);
      cnt_hs += (a_hs == 1'b0);
      cnt_ls += a_ls;
      cnt_c += a_fs;
    end
    chk("half_rate", "h_sync_low_clks", cnt_hs, 384);
    chk("half_rate", "line_start_clks", cnt_ls, 2);
    chk("half_rate", "frame_start_clks", cnt_c, 0);

    // Small raster vertical sync over exactly one frame at full rate.
    tick(1'b1, 1'b1);
    cnt_vs = 0;
    for (int i = 0; i < 120; i++) begin
      tick(1'b0, 1'b1);
      cnt_vs += s_vs;
    end
    chk("s_frame", "v_sync_high_clks", cnt_vs, 30);

    // Randomised pix_en with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
    end

    // Mid-frame reset on the small raster.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (s_fy == 5'd2 && s_fx == 5'd5) found = 1'b1;
      else tick(1'b0, 1'b1);
    end
    chk("midrst", "reached_target", found, 1);
    tick(1'b1, 1'b1);
    chk("midrst", "fetch_x", s_fx, 0);
    chk("midrst", "fetch_y", s_fy, 0);
    chk("midrst", "display_en", s_de, 0);
    chk("midrst", "h_sync", s_hs, 0);
    chk("midrst", "v_sync", s_vs, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("midrst_adv%0d", i), "frame_start", s_fs, i == 3);
    end

    // Frame counter: value after the third frame_start and wrap on the fourth (FCW=2).
    tick(1'b1, 1'b1);
    fs_seen = 0;
    steps = 0;
    while (fs_seen < 4 && steps < 1000) begin
      tick(1'b0, 1'b1);
      steps++;
      if (s_fs) begin
        fs_seen++;
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fs_seen == 3) chk("fcnt", "after_third", s_fc, 3);
        if (fs_seen == 4) chk("fcnt", "wrap", s_fc, 0);
`else
        chk("fcnt", "tied_zero", s_fc, 0);
`endif
      end
    end
    chk("fcnt", "frame_starts_seen", fs_seen, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
